instruction_encode: RTL and testbench

Buffered RV32 instruction encoder: the inverse of `instruction_decode`. It accepts decoded instruction fields (`opcode`, `optype`, register indices, `funct3`/`funct7`, `IMM_WIDTH`-bit immediate) over a valid/ready handshake. It packs them into a 32-bit instruction word and delivers the words in order from an internal FIFO over a second valid/ready handshake. It sits between the test/program generator and instruction memory, and is used for round-trip checks against `instruction_decode`.

---
 rtl/instruction_encode.sv | 123 ++++++++++++
 tb/tb_instruction_encode.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encode.sv
// Buffered RV32 instruction encoder: packs decoded fields into 32-bit words and queues them in a FIFO.
// Optional immediate range checking is compiled in with `define ENCODER_IMM_CHECK_EN.
package instruction_encode_pkg;
  localparam int IMM_WIDTH         = 21;
  localparam int INSTRUCTION_WIDTH = 32;

  typedef enum logic [2:0] {
    R_TYPE   = 3'd0,
    I_TYPE   = 3'd1,
    S_TYPE   = 3'd2,
    B_TYPE   = 3'd3,
    U_TYPE   = 3'd4,
    J_TYPE   = 3'd5,
    SYS_TYPE = 3'd6
  } instruction_op_type;
endpackage

module instruction_encode
  import instruction_encode_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [6:0]                   opcode,
  input  instruction_op_type           optype,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  input  logic [2:0]                   funct3,
  input  logic [6:0]                   funct7,
  input  logic [IMM_WIDTH-1:0]         imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         out_err,
  output logic [CNT_WIDTH-1:0]         enc_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                         err;
    logic [INSTRUCTION_WIDTH-1:0] word;
  } entry_t;

  entry_t enc_entry;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    enc_entry = '0;
    unique case (optype)
      R_TYPE:         enc_entry.word = {funct7, rs2, rs1, funct3, rd, opcode};
      I_TYPE,
      SYS_TYPE:       enc_entry.word = {imm[11:0], rs1, funct3, rd, opcode};
      S_TYPE:         enc_entry.word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      B_TYPE:         enc_entry.word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      U_TYPE:         enc_entry.word = {imm[19:0], rd, opcode};
      J_TYPE:         enc_entry.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        enc_entry.word = 32'h0000_0013;
        enc_entry.err  = 1'b1;
      end
    endcase
`ifdef ENCODER_IMM_CHECK_EN
    // Sign-extension bits above the encodable field must all match the field's sign bit.
    unique case (optype)
      I_TYPE, SYS_TYPE, S_TYPE:
        if (!((&imm[20:11]) || !(|imm[20:11]))) enc_entry.err = 1'b1;
      B_TYPE:
        if (!((&imm[20:12]) || !(|imm[20:12])) || imm[0]) enc_entry.err = 1'b1;
      J_TYPE:
        if (imm[0]) enc_entry.err = 1'b1;
      U_TYPE:
        if (imm[20]) enc_entry.err = 1'b1;
      default: ;
    endcase
`endif
  end

  entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept, pop;

  assign in_ready    = (occ_q != OCC_W'(DEPTH));
  assign out_valid   = (occ_q != '0);
  assign accept      = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign instruction = mem_q[head_q].word;
  assign out_err     = mem_q[head_q].err;
  assign enc_count   = cnt_q;

  always_comb begin
    head_d = pop    ? head_q + PTR_W'(1) : head_q;
    tail_d = accept ? tail_q + PTR_W'(1) : tail_q;
    cnt_d  = accept ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    occ_d  = occ_q;
    if (accept && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (pop && !accept) occ_d = occ_q - OCC_W'(1);
  end

  // NOTE: storage is reset because the head entry is visible on instruction/out_err straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
      if (accept) mem_q[tail_q] <= enc_entry;
    end
  end
endmodule

// File: tb/tb_instruction_encode.sv
// Self-checking bench for instruction_encode: directed cases plus randomized traffic
// against a queue-based reference model with arithmetic field packing.
module tb_instruction_encode;
  import instruction_encode_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  typedef struct {
    logic [6:0]         op;
    instruction_op_type ty;
    logic [4:0]         rd, rs1, rs2;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [20:0]        imm;
  } bundle_t;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0, out_ready = 1'b0;
  logic               in_ready, out_valid, out_err;
  logic [6:0]         opcode = '0, funct7 = '0;
  instruction_op_type optype = R_TYPE;
  logic [4:0]         rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]         funct3 = '0;
  logic [20:0]        imm = '0;
  logic [31:0]        instruction;
  logic [CW-1:0]      enc_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   model_cnt = 0;

  always #5 clk = ~clk;

  instruction_encode #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .optype(optype), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .instruction(instruction), .out_err(out_err),
    .enc_count(enc_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t mk(input int op, input instruction_op_type ty, input int rdv,
                                 input int r1, input int r2, input int f3v, input int f7v,
                                 input int immv);
    bundle_t b;
    b.op = 7'(op); b.ty = ty; b.rd = 5'(rdv); b.rs1 = 5'(r1); b.rs2 = 5'(r2);
    b.f3 = 3'(f3v); b.f7 = 7'(f7v); b.imm = 21'(immv);
    return b;
  endfunction

  function automatic int unsigned fld(input int unsigned v, input int lo, input int n);
    return (v >> lo) & ((32'd1 << n) - 1);
  endfunction

  // Reference packing built from shifts and masks of the numeric field values.
  function automatic exp_t ref_encode(input bundle_t b);
    int unsigned im  = 32'(b.imm);
    int          sim = (im >= (1 << 20)) ? int'(im) - (1 << 21) : int'(im);
    int unsigned base = 32'(b.op);
    exp_t e;
    e.err = 1'b0;
    case (b.ty)
      R_TYPE:   e.word = (32'(b.f7) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
                         | (32'(b.f3) << 12) | (32'(b.rd) << 7) | base;
      I_TYPE, SYS_TYPE:
                e.word = (fld(im, 0, 12) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
                         | (32'(b.rd) << 7) | base;
      S_TYPE:   e.word = (fld(im, 5, 7) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
                         | (32'(b.f3) << 12) | (fld(im, 0, 5) << 7) | base;
      B_TYPE:   e.word = (fld(im, 12, 1) << 31) | (fld(im, 5, 6) << 25) | (32'(b.rs2) << 20)
                         | (32'(b.rs1) << 15) | (32'(b.f3) << 12) | (fld(im, 1, 4) << 8)
                         | (fld(im, 11, 1) << 7) | base;
      U_TYPE:   e.word = (fld(im, 0, 20) << 12) | (32'(b.rd) << 7) | base;
      J_TYPE:   e.word = (fld(im, 20, 1) << 31) | (fld(im, 1, 10) << 21) | (fld(im, 11, 1) << 20)
                         | (fld(im, 12, 8) << 12) | (32'(b.rd) << 7) | base;
      default: begin
        e.word = 32'h0000_0013;
        e.err  = 1'b1;
      end
    endcase
`ifdef ENCODER_IMM_CHECK_EN
    case (b.ty)
      I_TYPE, SYS_TYPE, S_TYPE: if (sim < -2048 || sim > 2047) e.err = 1'b1;
      B_TYPE:   if (sim < -4096 || sim > 4095 || (im % 2) != 0) e.err = 1'b1;
      J_TYPE:   if ((im % 2) != 0) e.err = 1'b1;
      U_TYPE:   if (im >= (1 << 20)) e.err = 1'b1;
      default: ;
    endcase
`else
    if (sim == 0 && im != 0) e.err = 1'b1;  // unreachable: sim is zero only when im is zero
`endif
    return e;
  endfunction

  // One clock: compare outputs with the model, drive inputs, advance the model across the edge.
  task automatic cycle(input logic iv, input logic ordy, input bundle_t b);
    logic acc, pp;
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    check("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
    check("enc_count", 32'(enc_count), 32'(model_cnt));
    if (sb.size() != 0) begin
      check("head_word", instruction, sb[0].word);
      check("head_err", 32'(out_err), 32'(sb[0].err));
    end
    in_valid = iv; out_ready = ordy;
    opcode = b.op; optype = b.ty; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
    funct3 = b.f3; funct7 = b.f7; imm = b.imm;
    acc = iv && (sb.size() != DEPTH);
    pp  = ordy && (sb.size() != 0);
    @(posedge clk);
    if (pp) void'(sb.pop_front());
    if (acc) begin
      sb.push_back(ref_encode(b));
      model_cnt = (model_cnt + 1) % (1 << CW);
    end
    @(negedge clk);
  endtask

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.op  = 7'($urandom);
    b.ty  = instruction_op_type'($urandom_range(0, 7));
    b.rd  = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    b.f3  = 3'($urandom); b.f7  = 7'($urandom);
    b.imm = ($urandom_range(0, 1) == 0) ? 21'($urandom) : 21'($signed($urandom_range(0, 8191)) - 4096);
    return b;
  endfunction

  initial begin
    bundle_t idle, b;
    exp_t    e;
    idle = mk(0, R_TYPE, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);

    // Known encodings, each visible one cycle after its accept
    cycle(1, 1, mk(7'h33, R_TYPE, 3, 1, 2, 0, 0, 0));
    check("add_word", instruction, 32'h002081B3);
    cycle(1, 1, mk(7'h13, I_TYPE, 5, 0, 0, 0, 0, 21'h1FFFFF));
    check("addi_word", instruction, 32'hFFF00293);
    check("count_two", 32'(enc_count), 32'd2);
    cycle(1, 1, mk(7'h63, B_TYPE, 0, 1, 2, 0, 0, 21'h1FFFFC));
    check("beq_word", instruction, 32'hFE208EE3);
    cycle(1, 1, mk(7'h6F, J_TYPE, 1, 0, 0, 0, 0, 21'h000800));
    check("jal_word", instruction, 32'h001000EF);
    cycle(1, 1, mk(7'h13, I_TYPE, 0, 0, 0, 0, 0, 21'h000800));
    check("imm800_word", instruction, 32'h80000013);
`ifdef ENCODER_IMM_CHECK_EN
    check("imm800_err", 32'(out_err), 32'd1);
`else
    check("imm800_err", 32'(out_err), 32'd0);
`endif
    b = mk(7'h13, R_TYPE, 0, 0, 0, 0, 0, 0);
    b.ty = instruction_op_type'(3'd7);
    cycle(1, 1, b);
    check("unknown_word", instruction, 32'h00000013);
    check("unknown_err", 32'(out_err), 32'd1);
    cycle(0, 1, idle);

    // Back-pressure: fill beyond DEPTH, head must hold, then drain in order
    for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, rand_bundle());
    check("full_in_ready", 32'(in_ready), 32'd0);
    e = sb[0];
    cycle(1, 1, rand_bundle());  // full: only the pop happens
    check("after_pulse_in_ready", 32'(in_ready), 32'd1);
    check("after_pulse_size", 32'(sb.size()), DEPTH - 1);
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, idle);
    check("drained", 32'(out_valid), 32'd0);

    // Randomized traffic, with occasional stall bursts
    for (int i = 0; i < 400; i++) begin
      if (i % 50 < 8) cycle($urandom_range(0, 3) != 0, 1'b0, rand_bundle());
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rand_bundle());
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, idle);

    // Asynchronous reset with words queued
    for (int i = 0; i < 3; i++) cycle(1, 0, rand_bundle());
    check("queued_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_count", 32'(enc_count), 32'd0);
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle(1, 1, rand_bundle());
    cycle(0, 1, idle);
    cycle(0, 1, idle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
